// File: rtl/nonce_result_scanner.sv
// nonce_result_scanner
//   Reads back NUM_NONCES final H0 words left in memory by the hash engine,
//   compares each against a difficulty target, keeps the smallest H0 (lowest
//   index on a tie) and writes a 3-word result record {found, nonce, hash}.
//   Shares the engine's single-port synchronous memory; start is only issued
//   once the engine is finished, so the two never drive memory together.
//
// Ports
//   clk, reset          system clock, asynchronous active-high reset
//   start               begin a scan (honoured only in IDLE or DONE)
//   hash_addr           address of H0 for nonce 0 (nonce n at hash_addr+n)
//   result_addr         base address of the 3-word result record
//   target              a hash wins when H0 < target (unsigned)
//   done                level, high while in DONE
//   found, best_nonce,
//   best_hash           outcome of the most recent scan
//   mem_*               memory port; read data arrives two edges after the
//                       address is registered
//
// State | meaning
// IDLE     | waiting for the first start after reset
// READ     | issuing one read address per cycle
// DRAIN    | all addresses issued, collecting the remaining read data
// WR_FLAG  | register the found-flag write
// WR_NONCE | register the best-nonce write
// WR_HASH  | register the best-hash write, then close the write burst
// DONE     | record written, results held until the next start
module nonce_result_scanner #(
    parameter int NUM_NONCES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] hash_addr,
    input  logic [15:0] result_addr,
    input  logic [31:0] target,
    output logic        done,
    output logic        found,
    output logic [15:0] best_nonce,
    output logic [31:0] best_hash,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    localparam logic [15:0] N_WORDS = 16'(NUM_NONCES);

    typedef enum logic [2:0] {
        IDLE, READ, DRAIN, WR_FLAG, WR_NONCE, WR_HASH, DONE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] base_hash;
    logic [15:0] base_result;
    logic [31:0] tgt;
    logic [15:0] rd_cnt;
    logic [15:0] sm_cnt;
    logic        armed;    // read data is valid from the second edge after start
    logic        wr_last;  // hash write is on the bus; next edge ends the burst
    logic        accept;
    logic        sample;

    assign mem_clk = clk;

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        sample     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = READ;
                end
            end
            READ: begin
                sample = armed && (sm_cnt < N_WORDS);
                if (rd_cnt == N_WORDS) state_next = DRAIN;
            end
            DRAIN: begin
                sample = armed && (sm_cnt < N_WORDS);
                if (sample && (sm_cnt == N_WORDS - 16'd1)) state_next = WR_FLAG;
            end
            WR_FLAG:  state_next = WR_NONCE;
            WR_NONCE: state_next = WR_HASH;
            WR_HASH:  if (wr_last) state_next = DONE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            done           <= 1'b0;
            found          <= 1'b0;
            best_nonce     <= 16'd0;
            best_hash      <= 32'hFFFF_FFFF;
            mem_we         <= 1'b0;
            mem_addr       <= 16'd0;
            mem_write_data <= 32'd0;
            base_hash      <= 16'd0;
            base_result    <= 16'd0;
            tgt            <= 32'd0;
            rd_cnt         <= 16'd0;
            sm_cnt         <= 16'd0;
            armed          <= 1'b0;
            wr_last        <= 1'b0;
        end else begin
            state <= state_next;

            if (accept) begin
                base_hash   <= hash_addr;
                base_result <= result_addr;
                tgt         <= target;
                mem_we      <= 1'b0;
                mem_addr    <= hash_addr;
                rd_cnt      <= 16'd1;
                sm_cnt      <= 16'd0;
                done        <= 1'b0;
                found       <= 1'b0;
                best_hash   <= 32'hFFFF_FFFF;
                best_nonce  <= 16'd0;
                armed       <= 1'b0;
                wr_last     <= 1'b0;
            end

            if (state == READ) begin
                armed <= 1'b1;
                if (rd_cnt != N_WORDS) begin
                    mem_addr <= base_hash + rd_cnt;
                    rd_cnt   <= rd_cnt + 16'd1;
                end
            end

            if (sample) begin
                if (mem_read_data < tgt) found <= 1'b1;
                // strict compare keeps the earlier index on equal hashes
                if (mem_read_data < best_hash) begin
                    best_hash  <= mem_read_data;
                    best_nonce <= sm_cnt;
                end
                sm_cnt <= sm_cnt + 16'd1;
            end

            case (state)
                WR_FLAG: begin
                    mem_we         <= 1'b1;
                    mem_addr       <= base_result;
                    mem_write_data <= {31'd0, found};
                end
                WR_NONCE: begin
                    mem_addr       <= base_result + 16'd1;
                    mem_write_data <= {16'd0, best_nonce};
                end
                WR_HASH: begin
                    if (!wr_last) begin
                        mem_addr       <= base_result + 16'd2;
                        mem_write_data <= best_hash;
                        wr_last        <= 1'b1;
                    end else begin
                        mem_we <= 1'b0;
                        done   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nonce_result_scanner.sv
module tb_nonce_result_scanner;
    localparam int N = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        start1 = 1'b0;
    logic [15:0] hash_addr = 16'd0;
    logic [15:0] result_addr = 16'd0;
    logic [31:0] target = 32'd0;

    logic        done, found, mem_clk, mem_we;
    logic [15:0] best_nonce, mem_addr;
    logic [31:0] best_hash, mem_write_data, mem_read_data;
    logic        done1, found1, mem_clk1, mem_we1;
    logic [15:0] best_nonce1, mem_addr1;
    logic [31:0] best_hash1, mem_write_data1, mem_read_data1;

    logic [31:0] mem  [0:65535];
    logic [31:0] mem1 [0:65535];
    logic        ld_en = 1'b0;
    logic [15:0] ld_addr = 16'd0;
    logic [31:0] ld_data = 32'd0;
    int          wr_total = 0;

    logic [31:0] img [0:N-1];
    int          checks = 0;
    int          passes = 0;
    int          fails = 0;

    nonce_result_scanner #(.NUM_NONCES(N)) dut (
        .clk(clk), .reset(reset), .start(start),
        .hash_addr(hash_addr), .result_addr(result_addr), .target(target),
        .done(done), .found(found), .best_nonce(best_nonce), .best_hash(best_hash),
        .mem_clk(mem_clk), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    nonce_result_scanner #(.NUM_NONCES(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1),
        .hash_addr(hash_addr), .result_addr(result_addr), .target(target),
        .done(done1), .found(found1), .best_nonce(best_nonce1), .best_hash(best_hash1),
        .mem_clk(mem_clk1), .mem_we(mem_we1), .mem_addr(mem_addr1),
        .mem_write_data(mem_write_data1), .mem_read_data(mem_read_data1)
    );

    always #5 clk = ~clk;

    // synchronous memories: address seen at edge k+1, data sampled at edge k+2
    always @(posedge clk) begin
        mem_read_data  <= mem[mem_addr];
        mem_read_data1 <= mem1[mem_addr1];
        if (ld_en) begin
            mem[ld_addr]  <= ld_data;
            mem1[ld_addr] <= ld_data;
        end
        if (mem_we) begin
            mem[mem_addr] <= mem_write_data;
            wr_total      <= wr_total + 1;
        end
        if (mem_we1) mem1[mem_addr1] <= mem_write_data1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ld(input logic [15:0] a, input logic [31:0] d);
        ld_addr = a;
        ld_data = d;
        ld_en   = 1'b1;
        @(posedge clk);
        #1;
        ld_en = 1'b0;
    endtask

    task automatic load_img(input logic [15:0] base, input logic [15:0] ra);
        for (int i = 0; i < N; i++) ld(base + 16'(i), img[i]);
        for (int i = 0; i < 3; i++) ld(ra + 16'(i), 32'hDEAD_0000 + 32'(i));
    endtask

    // Reference: the winner is the overall minimum and its first occurrence;
    // a winner exists exactly when that minimum is below the target.
    task automatic run_scan(input logic [15:0] ha, input logic [15:0] ra,
                            input logic [31:0] tg, input bit keep);
        logic [31:0] mn;
        int          idx;
        int          cyc;
        int          w0;
        bit          addr_ok;
        logic        exp_found;
        mn = 32'hFFFF_FFFF;
        foreach (img[i]) if (img[i] < mn) mn = img[i];
        idx = 0;
        for (int i = N - 1; i >= 0; i--) if (img[i] == mn) idx = i;
        exp_found = (mn < tg);

        hash_addr   = ha;
        result_addr = ra;
        target      = tg;
        start       = 1'b1;
        w0          = wr_total;
        @(posedge clk);
        #1;
        if (!keep) start = 1'b0;
        chk("done_drop", done, 0);
        addr_ok = (mem_addr === ha);
        cyc = 0;
        while (!done && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc < N && mem_addr !== ha + 16'(cyc)) addr_ok = 1'b0;
        end
        chk("latency", cyc, N + 5);
        chk("read_addr_seq", addr_ok, 1);
        chk("found", found, exp_found);
        chk("best_nonce", best_nonce, idx);
        chk("best_hash", best_hash, mn);
        chk("rec_flag", mem[ra], {31'd0, exp_found});
        chk("rec_nonce", mem[ra + 16'd1], idx);
        chk("rec_hash", mem[ra + 16'd2], mn);
        chk("write_count", wr_total - w0, 3);
    endtask

    initial begin
        logic [15:0] base;
        logic [31:0] tg;
        int          cyc;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_done", done, 0);
        chk("rst_found", found, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_best_nonce", best_nonce, 0);
        chk("rst_best_hash", best_hash, 32'hFFFF_FFFF);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_write_data, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // ascending values, winner below target
        foreach (img[i]) img[i] = 32'h1000_0000 + 32'(i);
        load_img(16'h0100, 16'h0200);
        run_scan(16'h0100, 16'h0200, 32'h1000_0005, 1'b0);

        // no winner, tie resolved to lower index
        foreach (img[i]) img[i] = 32'hFFFF_0000;
        img[3] = 32'h0000_0400;
        img[9] = 32'h0000_0400;
        load_img(16'h0100, 16'h0200);
        run_scan(16'h0100, 16'h0200, 32'h0000_0100, 1'b0);

        // all ones
        foreach (img[i]) img[i] = 32'hFFFF_FFFF;
        load_img(16'h0100, 16'h0200);
        run_scan(16'h0100, 16'h0200, 32'h8000_0000, 1'b0);

        // address wrap past 0xFFFF
        foreach (img[i]) img[i] = $urandom;
        load_img(16'hFFF8, 16'h0040);
        run_scan(16'hFFF8, 16'h0040, $urandom, 1'b0);

        // reset while the nonce write is being set up
        foreach (img[i]) img[i] = 32'h1000_0000 + 32'(i);
        load_img(16'h0100, 16'h0200);
        hash_addr   = 16'h0100;
        result_addr = 16'h0200;
        target      = 32'h1000_0005;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (N + 2) @(posedge clk);
        #1;
        chk("pre_rst_we", mem_we, 1);
        reset = 1'b1;
        #1;
        chk("midrst_we", mem_we, 0);
        chk("midrst_done", done, 0);
        chk("midrst_hash", best_hash, 32'hFFFF_FFFF);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("midrst_rec_nonce", mem[16'h0201], 32'hDEAD_0001);
        chk("midrst_rec_hash", mem[16'h0202], 32'hDEAD_0002);
        run_scan(16'h0100, 16'h0200, 32'h1000_0005, 1'b0);

        // back-to-back with start held high, target changed while in DONE
        foreach (img[i]) img[i] = $urandom | 32'h0001_0000;
        img[5] = 32'h0000_1000;
        load_img(16'h0400, 16'h0500);
        run_scan(16'h0400, 16'h0500, 32'h0000_2000, 1'b1);
        run_scan(16'h0400, 16'h0500, 32'h0000_0000, 1'b1);
        start = 1'b0;

        // randomized scans, some with heavy ties and target equal to a hash
        for (int r = 0; r < 4; r++) begin
            base = 16'($urandom);
            foreach (img[i]) img[i] = (r[0]) ? 32'($urandom_range(0, 3)) : $urandom;
            tg = (r[1]) ? img[$urandom_range(0, N - 1)] : $urandom;
            load_img(base, base + 16'h1000);
            run_scan(base, base + 16'h1000, tg, 1'b0);
        end

        // single-nonce build
        ld(16'h0300, 32'h0000_0001);
        hash_addr   = 16'h0300;
        result_addr = 16'h0310;
        target      = 32'h0000_0002;
        start1      = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        cyc = 0;
        while (!done1 && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("n1_latency", cyc, 6);
        chk("n1_found", found1, 1);
        chk("n1_best_nonce", best_nonce1, 0);
        chk("n1_best_hash", best_hash1, 1);
        chk("n1_rec_flag", mem1[16'h0310], 1);
        chk("n1_rec_hash", mem1[16'h0312], 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/nonce_result_scanner.md
Name: nonce_result_scanner

Overview:
- Downstream consumer of the parallel bitcoin hash engine.
- After the engine writes its NUM_NONCES final H0 words to memory, this block reads them back and compares each against a difficulty target.
- Selects the winning nonce (smallest H0, lowest index on tie) and writes a 3-word result record to memory.
- Shares the engine's single-port synchronous memory interface; the two blocks never drive memory at the same time (start is issued only after the engine's done).

Parameters:
- NUM_NONCES, 16, number of consecutive H0 words to scan; legal 1..65535.

Ports:
- clk  in  1  system clock; also forwarded to mem_clk.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a scan; sampled only in IDLE or DONE.
- hash_addr  in  16  base address of H0 word for nonce 0; nonce n is at hash_addr+n.
- result_addr  in  16  base address of the 3-word result record.
- target  in  32  unsigned threshold; a hash wins if H0 < target.
- done  out  1  level; high in DONE.
- found  out  1  at least one H0 < target in the last scan.
- best_nonce  out  16  index of the minimum H0.
- best_hash  out  32  minimum H0 value.
- mem_clk  out  1  equals clk.
- mem_we  out  1  memory write enable.
- mem_addr  out  16  memory address, registered.
- mem_write_data  out  32  memory write data, registered.
- mem_read_data  in  32  memory read data.

Behaviour:
- Reset (asynchronous, active-high) values:
  - state=IDLE.
  - done, found, mem_we = 0.
  - best_nonce, mem_addr, mem_write_data = 0.
  - best_hash = 32'hFFFFFFFF.
- Memory timing: the address registered at edge k is sampled from mem_read_data at edge k+2. Writes occur at the edge where mem_we=1 is observed with mem_addr/mem_write_data.
- States: IDLE, READ, DRAIN, WR_FLAG, WR_NONCE, WR_HASH, DONE.
- IDLE/DONE with start=1, at edge 0:
  - Latch hash_addr, result_addr and target.
  - mem_we<=0, mem_addr<=hash_addr, rd_cnt<=1, sm_cnt<=0.
  - done<=0, found<=0, best_hash<=32'hFFFFFFFF, best_nonce<=0.
  - Go to READ.
- READ: at each edge, mem_addr<=hash_addr+rd_cnt and rd_cnt++ until rd_cnt reaches NUM_NONCES, then hold mem_addr and go to DRAIN. Each read address is issued exactly once.
- Sampling runs in READ and DRAIN, starting from the second edge after start (edge 2). At each edge while sm_cnt<NUM_NONCES, word v=mem_read_data is processed and sm_cnt++:
  - If v<target (32-bit unsigned), set found<=1.
  - If v<best_hash (strict), set best_hash<=v and best_nonce<=sm_cnt. Ties keep the lower index.
  - When the last sample is taken (edge NUM_NONCES+1), go to WR_FLAG.
- Writes, all registered:
  - WR_FLAG (edge N+2): mem_we<=1, mem_addr<=result_addr, mem_write_data<={31'b0,found}.
  - WR_NONCE (edge N+3): mem_addr<=result_addr+1, mem_write_data<={16'b0,best_nonce}.
  - WR_HASH (edge N+4): mem_addr<=result_addr+2, mem_write_data<=best_hash.
  - Next edge (N+5): mem_we<=0, done<=1, go to DONE.
- Latency: done rises at edge NUM_NONCES+5 after start is sampled (21 cycles for the default of 16).
- found, best_nonce and best_hash hold their values in DONE until the next accepted start.
- start is ignored in every state except IDLE and DONE.
- Address arithmetic is 16-bit modulo: hash_addr+n and result_addr+2 wrap past 16'hFFFF.
- NUM_NONCES=1: READ lasts one edge, then DRAIN; the single sample is at edge 2.
- target=0: no hash can win, so found=0; best_* is still reported.
- All H0 words equal 32'hFFFFFFFF: best_hash=32'hFFFFFFFF and best_nonce=0.
- Reset asserted mid-scan or mid-write: immediate return to reset values. mem_we drops asynchronously, no further writes occur, and the partial record is not completed.

Test Plan:
- Ascending scan: memory[0x100+n]=0x10000000+n for n=0..15, target=0x10000005, result_addr=0x200, start -> done at cycle 21; mem[0x200]=1, mem[0x201]=0, mem[0x202]=0x10000000; exactly 3 write cycles.
- No winner with tie: H0[3]=H0[9]=0x00000400 and all others 0xFFFF0000, target=0x00000100 -> found=0, best_nonce=3, best_hash=0x00000400; mem[0x200]=0.
- Address wrap: hash_addr=0xFFF8, NUM_NONCES=16 -> reads 0xFFF8..0xFFFF then 0x0000..0x0007 in order, one per cycle; the result is correct.
- Reset mid-op: assert reset during WR_NONCE -> mem_we=0 immediately, done=0, best_hash=0xFFFFFFFF; mem[0x201] and mem[0x202] unchanged; a new start gives a full correct record.
- Back-to-back: start held high through DONE with a changed target -> second scan begins the edge after done; done drops, then re-rises 21 cycles later with updated found; start pulses while busy are ignored.
- NUM_NONCES=1 build: H0[0]=0x00000001, target=0x00000002 -> found=1, best_nonce=0, done at cycle 6.
